// File: rtl/pending_encoder_16x4_if.sv
// -----------------------------------------------------------------------------
// pending_encoder_16x4_if
// Handshake bundle between request sources, the pending encoder and the
// consumer of the encoded index.
//
// Signals (vectors are ascending, element [0] is the MSB / line 0):
//   en          capture enable; when 0, req is ignored
//   req         request lines, req[i] requests index i
//   out_ready   consumer accepts the presented index
//   out_valid   idx is valid
//   idx         encoded index, idx[0] = MSB
//   out_onehot  one-hot of idx while out_valid, else all 0
//   busy        any line pending or presented
//
// Modports:
//   master  request source / consumer side (drives en, req, out_ready)
//   slave   encoder side (drives out_valid, idx, out_onehot, busy)
// -----------------------------------------------------------------------------
interface pending_encoder_16x4_if #(
    parameter int N     = 16,
    parameter int IDX_W = 4
);
    logic             en;
    logic [0:N-1]     req;
    logic             out_ready;
    logic             out_valid;
    logic [0:IDX_W-1] idx;
    logic [0:N-1]     out_onehot;
    logic             busy;

    modport master (
        output en, req, out_ready,
        input  out_valid, idx, out_onehot, busy
    );

    modport slave (
        input  en, req, out_ready,
        output out_valid, idx, out_onehot, busy
    );
endinterface

// File: rtl/pending_encoder_16x4.sv
// -----------------------------------------------------------------------------
// pending_encoder_16x4
// Collects request lines into a pending set and hands them out one at a time
// as a 4-bit index over a valid/ready handshake. A served line is cleared on
// acceptance; a line that is requested again re-enters the set.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    pending_encoder_16x4_if.slave (en, req, out_ready in;
//          out_valid, idx, out_onehot, busy out)
//
// Build option:
//   RR_ARB_EN  defined   -> round-robin selection, search starts after the
//                           last accepted index
//              undefined -> fixed priority, lowest index wins
// -----------------------------------------------------------------------------
module pending_encoder_16x4 #(
    parameter int N     = 16,
    parameter int IDX_W = 4
) (
    input logic                   clk,
    input logic                   rst_n,
    pending_encoder_16x4_if.slave bus
);

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_t;

    state_t           state;
    logic [0:N-1]     pend;
    logic [0:N-1]     clr;
    logic [0:N-1]     cap;
    logic [0:N-1]     oh;
    logic [0:IDX_W-1] idx_q;
    logic             valid_q;
    logic [0:IDX_W-1] sel_idx;
    logic             accept;

`ifdef RR_ARB_EN
    logic [0:IDX_W-1] last;

    // First pending line at or after last+1, wrapping N-1 -> 0.
    function automatic logic [0:IDX_W-1] sel_rr(input logic [0:N-1]     p,
                                                input logic [0:IDX_W-1] after);
        logic [0:IDX_W-1] r;
        logic [0:IDX_W-1] j;
        logic             found;
        r     = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j = IDX_W'((int'(after) + k) % N);
            if (!found && p[j]) begin
                r     = j;
                found = 1'b1;
            end
        end
        return r;
    endfunction
`else
    // Lowest pending index wins; scanning downward leaves the lowest in r.
    function automatic logic [0:IDX_W-1] sel_fixed(input logic [0:N-1] p);
        logic [0:IDX_W-1] r;
        r = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (p[IDX_W'(i)]) r = IDX_W'(i);
        end
        return r;
    endfunction
`endif

    assign accept = valid_q && bus.out_ready;

    always_comb begin
        oh = '0;
        if (valid_q) oh[idx_q] = 1'b1;
        // The presented line is the only one that can be cleared.
        clr = accept ? oh : '0;
        cap = bus.en ? bus.req : '0;
`ifdef RR_ARB_EN
        sel_idx = sel_rr(pend, last);
`else
        sel_idx = sel_fixed(pend);
`endif
    end

    // Pending set: set wins over clear, so a line requested in its own
    // serve cycle stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend <= '0;
        end else begin
            pend <= (pend & ~clr) | cap;
        end
    end

    // Presentation FSM: the index is frozen while PRESENT, so a newly
    // pending higher-priority line never preempts a presented one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            valid_q <= 1'b0;
            idx_q   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|pend) begin
                        idx_q   <= sel_idx;
                        valid_q <= 1'b1;
                        state   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef RR_ARB_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last <= '0;
        end else if (accept) begin
            last <= idx_q;
        end
    end
`endif

    assign bus.out_valid  = valid_q;
    assign bus.idx        = idx_q;
    assign bus.out_onehot = oh;
    assign bus.busy       = |pend;

endmodule

// File: tb/tb_pending_encoder_16x4.sv
// -----------------------------------------------------------------------------
// tb_pending_encoder_16x4
// Scoreboard bench: each stimulus pushes the index order it should produce;
// a monitor pops and compares on every accepted handshake. Timing, reset and
// gating behaviour are checked directly in the stimulus sequence.
// -----------------------------------------------------------------------------
module tb_pending_encoder_16x4;
    localparam int N     = 16;
    localparam int IDX_W = 4;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    pending_encoder_16x4_if #(.N(N), .IDX_W(IDX_W)) bus ();

    pending_encoder_16x4 #(.N(N), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [0:N-1] line_oh(input int i);
        logic [0:N-1] v;
        logic [IDX_W-1:0] k;
        k    = i[IDX_W-1:0];
        v    = '0;
        v[k] = 1'b1;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((bus.busy !== 1'b0 || bus.out_valid !== 1'b0) && n < 40) begin
            tick();
            n++;
        end
        check({tag, "_drain_timeout"}, 32'(n < 40), 32'd1);
    endtask

    // Scoreboard monitor: one pop per accepted index.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            int e;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_idx", 32'(bus.idx), 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("sb_idx", 32'(bus.idx), 32'(e));
                check("sb_onehot", 32'(bus.out_onehot), 32'(line_oh(e)));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [5:0] pat;

        rst_n         = 1'b0;
        bus.en        = 1'b0;
        bus.req       = '0;
        bus.out_ready = 1'b0;

        // Reset state, before any clock edge
        #2;
        check("rst_valid",  32'(bus.out_valid),  32'd0);
        check("rst_idx",    32'(bus.idx),        32'd0);
        check("rst_onehot", 32'(bus.out_onehot), 32'd0);
        check("rst_busy",   32'(bus.busy),       32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Asynchronous reset while presenting with all lines pending
        bus.en  = 1'b1;
        bus.req = '1;
        tick();
        bus.req = '0;
        tick();
        check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
        check("pre_rst_busy",  32'(bus.busy),      32'd1);
`ifdef RR_ARB_EN
        check("pre_rst_idx",   32'(bus.idx),       32'd1);
`else
        check("pre_rst_idx",   32'(bus.idx),       32'd0);
`endif
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid",  32'(bus.out_valid),  32'd0);
        check("mid_rst_idx",    32'(bus.idx),        32'd0);
        check("mid_rst_onehot", 32'(bus.out_onehot), 32'd0);
        check("mid_rst_busy",   32'(bus.busy),       32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_busy",  32'(bus.busy),       32'd0);

        // Single line 5, latency and one-cycle valid
        bus.out_ready = 1'b1;
        bus.req       = line_oh(5);
        exp_q.push_back(5);
        tick();
        bus.req = '0;
        check("single_valid_early", 32'(bus.out_valid), 32'd0);
        check("single_busy",        32'(bus.busy),      32'd1);
        tick();
        check("single_valid",  32'(bus.out_valid),  32'd1);
        check("single_idx",    32'(bus.idx),        32'b0101);
        check("single_onehot", 32'(bus.out_onehot), 32'(line_oh(5)));
        tick();
        check("single_valid_drop", 32'(bus.out_valid), 32'd0);
        check("single_busy_after", 32'(bus.busy),      32'd0);

        // Multiple lines 3, 9, 12 with one-cycle gaps
        bus.req = line_oh(3) | line_oh(9) | line_oh(12);
`ifdef RR_ARB_EN
        exp_q.push_back(9);
        exp_q.push_back(12);
        exp_q.push_back(3);
`else
        exp_q.push_back(3);
        exp_q.push_back(9);
        exp_q.push_back(12);
`endif
        tick();
        bus.req = '0;
        pat = '0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pat = {pat[4:0], bus.out_valid};
        end
        check("multi_valid_pattern", 32'(pat), 32'b101010);
        check("multi_busy_after", 32'(bus.busy), 32'd0);

        // Backpressure: presented index holds, no preemption by line 1
        bus.out_ready = 1'b0;
        bus.req       = line_oh(3);
        exp_q.push_back(3);
        exp_q.push_back(1);
        tick();
        bus.req = '0;
        tick();
        check("bp_first_valid", 32'(bus.out_valid), 32'd1);
        check("bp_first_idx",   32'(bus.idx),       32'd3);
        bus.req = line_oh(1);
        tick();
        bus.req = '0;
        tick();
        check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
        check("bp_hold_idx",   32'(bus.idx),       32'd3);
        check("bp_hold_busy",  32'(bus.busy),      32'd1);
        bus.out_ready = 1'b1;
        tick();
        check("bp_bubble", 32'(bus.out_valid), 32'd0);
        tick();
        check("bp_second_valid", 32'(bus.out_valid), 32'd1);
        check("bp_second_idx",   32'(bus.idx),       32'd1);
        tick();
        check("bp_done_valid", 32'(bus.out_valid), 32'd0);
        check("bp_done_busy",  32'(bus.busy),      32'd0);

        // Capture gating
        bus.en  = 1'b0;
        bus.req = line_oh(7);
        tick();
        bus.req = '0;
        tick();
        tick();
        check("en0_valid", 32'(bus.out_valid), 32'd0);
        check("en0_busy",  32'(bus.busy),      32'd0);
        bus.en  = 1'b1;
        bus.req = line_oh(7);
        exp_q.push_back(7);
        tick();
        bus.req = '0;
        tick();
        check("en1_valid", 32'(bus.out_valid), 32'd1);
        check("en1_idx",   32'(bus.idx),       32'd7);
        tick();

        // Arbitration with lines 2 and 7 held high for four accepts
`ifdef RR_ARB_EN
        exp_q.push_back(2);
        exp_q.push_back(7);
        exp_q.push_back(2);
        exp_q.push_back(7);
        exp_q.push_back(2);
        exp_q.push_back(7);
`else
        exp_q.push_back(2);
        exp_q.push_back(2);
        exp_q.push_back(2);
        exp_q.push_back(2);
        exp_q.push_back(2);
        exp_q.push_back(7);
`endif
        bus.req = line_oh(2) | line_oh(7);
        repeat (9) tick();
        bus.req = '0;
        drain("arb");
        check("sb_all_consumed", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
